// File: rtl/inv_key_scheduler.sv
// ---------------------------------------------------------------------------
// inv_key_scheduler
//
// Generates AES-128 round keys in reverse order (10 down to 0) for the
// inverse-cipher datapath. One 128-bit key register is used. A load first
// rolls the cipher key forward to the round-10 key. Each consumer request
// then rolls the register back by one round.
//
// The S-box is external and shared. sbox_in carries RotWord of the relevant
// w3 word. The substituted word returns on sbox_out in the same cycle.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   load         start pulse: latch cipher_key, begin forward expansion
//   cipher_key   AES-128 key, w0 = [127:96] ... w3 = [31:0]
//   key_req      advance to the next lower round key (SERVE only)
//   sbox_in      word presented to the shared S-box (RotWord applied)
//   sbox_out     SubWord(sbox_in), combinational return
//   round_key    current round key, 0 when key_valid = 0
//   round_idx    index of round_key (10 ... 0), 0 when key_valid = 0
//   key_valid    round_key / round_idx are valid
//   busy         forward expansion in progress
//   done         one-cycle pulse after round key 0 is consumed
//   key_mismatch self-check flag
//
// Optional build macro
//   KEY_SELFCHECK_EN : when defined, a copy of the cipher key is captured on
//   load. On consumption of round key 0 the regenerated key is compared
//   against that copy. key_mismatch holds the result until the next load or
//   reset. When undefined, key_mismatch is tied to 0.
// ---------------------------------------------------------------------------
module inv_key_scheduler #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] cipher_key,
    input  logic         key_req,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done,
    output logic         key_mismatch
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t       state_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd_reg;
    logic         key_valid_reg;
    logic         busy_reg;
    logic         done_reg;

    // Round constant for round r (1..10), placed in the top byte of the word.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    // Word views of the current key, the next-forward key and the
    // previous-round key.
    logic [31:0] w_cur [4];
    logic [31:0] w_fwd [4];
    logic [31:0] w_rev [4];
    logic [31:0] fwd_t;
    logic [31:0] rev_t;

    // Forward step uses Rcon of the round being produced (rnd+1). The
    // reverse step uses Rcon of the round being undone (rnd).
    assign fwd_t = sbox_out ^ {rcon(rnd_reg + 4'd1), 24'h0};
    assign rev_t = sbox_out ^ {rcon(rnd_reg), 24'h0};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign w_cur[gi] = key_reg[127 - 32*gi -: 32];
        end

        assign w_fwd[0] = w_cur[0] ^ fwd_t;
        assign w_rev[0] = w_cur[0] ^ rev_t;

        // Forward words chain on the freshly produced word. Reverse words
        // only need neighbouring words of the current round.
        for (gi = 1; gi < 4; gi++) begin : g_chain
            assign w_fwd[gi] = w_cur[gi] ^ w_fwd[gi-1];
            assign w_rev[gi] = w_cur[gi] ^ w_cur[gi-1];
        end
    endgenerate

    // In FWD, SubWord acts on the current w3. In SERVE, it acts on the
    // previous round's w3, which is recovered as w3' ^ w2'.
    always_comb begin
        sbox_in = 32'h0;
        case (state_reg)
            FWD:     sbox_in = rot_word(w_cur[3]);
            SERVE:   sbox_in = rot_word(w_rev[3]);
            default: sbox_in = 32'h0;
        endcase
    end

`ifdef KEY_SELFCHECK_EN
    logic [127:0] key_copy_reg;
    logic         key_mismatch_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            key_reg       <= '0;
            rnd_reg       <= '0;
            key_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef KEY_SELFCHECK_EN
            key_copy_reg     <= '0;
            key_mismatch_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                // Load has priority over everything, in every state.
                state_reg     <= FWD;
                key_reg       <= cipher_key;
                rnd_reg       <= '0;
                key_valid_reg <= 1'b0;
                busy_reg      <= 1'b1;
`ifdef KEY_SELFCHECK_EN
                key_copy_reg     <= cipher_key;
                key_mismatch_reg <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        // key_req has no effect here.
                    end
                    FWD: begin
                        key_reg <= {w_fwd[0], w_fwd[1], w_fwd[2], w_fwd[3]};
                        rnd_reg <= rnd_reg + 4'd1;
                        if (rnd_reg == LAST - 4'd1) begin
                            state_reg     <= SERVE;
                            busy_reg      <= 1'b0;
                            key_valid_reg <= 1'b1;
                        end
                    end
                    SERVE: begin
                        if (key_req) begin
                            if (rnd_reg != 4'd0) begin
                                key_reg <= {w_rev[0], w_rev[1], w_rev[2], w_rev[3]};
                                rnd_reg <= rnd_reg - 4'd1;
                            end else begin
                                state_reg     <= IDLE;
                                key_valid_reg <= 1'b0;
                                done_reg      <= 1'b1;
`ifdef KEY_SELFCHECK_EN
                                key_mismatch_reg <= (key_reg != key_copy_reg);
`endif
                            end
                        end
                    end
                    default: begin
                        state_reg     <= IDLE;
                        key_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign round_key = key_valid_reg ? key_reg : 128'h0;
    assign round_idx = key_valid_reg ? rnd_reg : 4'h0;
    assign key_valid = key_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

`ifdef KEY_SELFCHECK_EN
    assign key_mismatch = key_mismatch_reg;
`else
    assign key_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_inv_key_scheduler.sv
// ---------------------------------------------------------------------------
// tb_inv_key_scheduler
//
// Drives inv_key_scheduler with directed scenarios and then random traffic.
// The S-box is built from GF(2^8) arithmetic. The reference model expands
// each loaded key with the standard 44-word AES schedule. It tracks each
// session as "cycles since load" and "keys consumed". A single negedge
// process compares every output against that model on every cycle.
// ---------------------------------------------------------------------------
module tb_inv_key_scheduler;

    logic         clk;
    logic         reset;
    logic         load;
    logic [127:0] cipher_key;
    logic         key_req;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;
    logic         key_mismatch;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K1_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    inv_key_scheduler #(.NR(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .cipher_key   (cipher_key),
        .key_req      (key_req),
        .sbox_in      (sbox_in),
        .sbox_out     (sbox_out),
        .round_key    (round_key),
        .round_idx    (round_idx),
        .key_valid    (key_valid),
        .busy         (busy),
        .done         (done),
        .key_mismatch (key_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- S-box from field arithmetic ----------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    assign sbox_out = {sbox_tab[sbox_in[31:24]], sbox_tab[sbox_in[23:16]],
                       sbox_tab[sbox_in[15:8]],  sbox_tab[sbox_in[7:0]]};

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rc(input int i);
        logic [7:0] r = 8'h01;
        for (int j = 1; j < i; j++) r = xtime(r);
        return r;
    endfunction

    // Standard 44-word key expansion; returns round keys 0..10.
    function automatic logic [10:0][127:0] expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [10:0][127:0] rk;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word(rot(t)) ^ {rc(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    // ---------------- Reference model ----------------
    logic [10:0][127:0] m_rk;
    logic               m_active;
    int                 m_age;    // cycles since load (1 = first cycle after it)
    int                 m_cons;   // round keys consumed in this session
    logic               m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_cons   <= 0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (load) begin
                m_rk     <= expand(cipher_key);
                m_active <= 1'b1;
                m_age    <= 1;
                m_cons   <= 0;
            end else if (m_active) begin
                if (m_age <= 10) begin
                    m_age <= m_age + 1;
                end else if (key_req) begin
                    if (m_cons < 10) begin
                        m_cons <= m_cons + 1;
                    end else begin
                        m_active <= 1'b0;
                        m_done   <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            logic e_valid, e_busy;
            int   e_idx;
            e_busy  = m_active && (m_age <= 10);
            e_valid = m_active && (m_age >= 11);
            e_idx   = 10 - m_cons;
            chk("key_valid", 128'(key_valid), 128'(e_valid));
            chk("busy", 128'(busy), 128'(e_busy));
            chk("done", 128'(done), 128'(m_done));
            chk("key_mismatch", 128'(key_mismatch), 128'(0));
            if (e_valid) begin
                chk("round_idx", 128'(round_idx), 128'(e_idx));
                chk("round_key", round_key, m_rk[e_idx]);
                if (e_idx > 0)
                    chk("sbox_in_serve", 128'(sbox_in), 128'(rot(m_rk[e_idx-1][31:0])));
            end else begin
                chk("round_key_zero", round_key, 128'h0);
            end
            if (!m_active)
                chk("sbox_in_idle", 128'(sbox_in), 128'h0);
            else if (e_busy)
                chk("sbox_in_fwd", 128'(sbox_in), 128'(rot(m_rk[m_age-1][31:0])));
        end
    end

    // ---------------- Stimulus ----------------
    task automatic do_load(input logic [127:0] k, output int lat);
        load       = 1'b1;
        cipher_key = k;
        lat        = 0;
        @(negedge clk);
        load = 1'b0;
        lat  = 1;
        while (!key_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        reset      = 1'b1;
        load       = 1'b0;
        key_req    = 1'b0;
        cipher_key = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(key_valid), 128'(0));
        chk("rst_key", round_key, 128'h0);
        chk("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // 1: load, latency and round-10 key
        do_load(K1, lat);
        chk("t1_latency", 128'(lat), 128'(11));
        chk("t1_idx", 128'(round_idx), 128'(10));
        chk("t1_r10", round_key, K1_R10);

        // 2: one request
        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        chk("t2_idx", 128'(round_idx), 128'(9));
        chk("t2_r9", round_key, K1_R9);
        @(negedge clk);
        chk("t2_stable", round_key, K1_R9);

        // 3: hold key_req from round 10 down to 0
        do_load(K1, lat);
        chk("t3_latency", 128'(lat), 128'(11));
        key_req = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            chk("t3_idx", 128'(round_idx), 128'(r));
            if (r == 1) chk("t3_r1", round_key, K1_R1);
            if (r == 0) chk("t3_r0", round_key, K1);
            @(negedge clk);
        end
        key_req = 1'b0;
        chk("t3_done", 128'(done), 128'(1));
        chk("t3_valid_off", 128'(key_valid), 128'(0));
        chk("t3_mismatch", 128'(key_mismatch), 128'(0));
        @(negedge clk);
        chk("t3_done_once", 128'(done), 128'(0));

        // 4: reload during forward expansion
        load = 1'b1;
        cipher_key = K1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);   // now in forward cycle 5
        chk("t4_busy", 128'(busy), 128'(1));
        do_load(K2, lat);
        chk("t4_latency", 128'(lat), 128'(11));
        chk("t4_r10", round_key, K2_R10);

        // 5: load and key_req together at round 4
        key_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_idx", 128'(round_idx), 128'(4));
        load = 1'b1;
        cipher_key = K1;
        @(negedge clk);
        load = 1'b0;
        key_req = 1'b0;
        chk("t5_valid_off", 128'(key_valid), 128'(0));
        chk("t5_no_done", 128'(done), 128'(0));
        chk("t5_busy", 128'(busy), 128'(1));
        lat = 1;
        while (!key_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_relatency", 128'(lat), 128'(11));

        // 6: asynchronous reset in the middle of SERVE
        key_req = 1'b1;
        repeat (4) @(negedge clk);
        key_req = 1'b0;
        chk("t6_idx", 128'(round_idx), 128'(6));
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", 128'(key_valid), 128'(0));
        chk("t6_key", round_key, 128'h0);
        chk("t6_idx0", 128'(round_idx), 128'(0));
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_done", 128'(done), 128'(0));
        chk("t6_sbox", 128'(sbox_in), 128'h0);
        @(negedge clk);
        reset = 1'b0;
        key_req = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_ignored", 128'(key_valid), 128'(0));
        end
        key_req = 1'b0;

        // Random traffic, checked every cycle by the compare process
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = 1'b0;
            load  = ($urandom_range(0, 99) < 4);
            if (load) cipher_key = {$urandom, $urandom, $urandom, $urandom};
            key_req = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 999) < 2) reset = 1'b1;
        end
        @(negedge clk);
        reset   = 1'b0;
        load    = 1'b0;
        key_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
